// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access engine
//
// Turns a load/store from the EX/MEM register into one aligned word request
// with byte enables, holds it until the data memory responds (or the wait
// budget runs out), freezes the pipeline meanwhile, and returns the
// sign/zero-extended load result. Non-memory instructions pass with no stall.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   valid_i, mem_read_i,
//   mem_write_i, funct3_i           instruction control from EX/MEM
//   addr_i, rs2_val_i               byte address and store data
//   dmem_address, dmem_read,
//   dmem_write, dmem_mbe,
//   dmem_wdata                      registered request to data memory
//   dmem_resp, dmem_rdata           one-cycle completion and read data
//   load_data_o                     extended load result, valid in DONE
//   stall_o                         freeze upstream stages and MEM/WB
//   misalign_o                      misaligned access, no request made
//   bus_err_o                       timeout abort, high for the DONE cycle
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_val_i,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [31:2]   addr_q;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          rd_q;
  logic [3:0]    mbe_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   load_q;
  logic          bus_err_q;

  logic          mem_op, mis_raw, go, timeout;
  logic [3:0]    mbe_n;
  logic [31:0]   wdata_n;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word.
  always_comb begin
    mem_op  = valid_i & (mem_read_i | mem_write_i);
    mis_raw = 1'b0;
    mbe_n   = 4'hF;
    wdata_n = 32'h0;
    case (funct3_i[1:0])
      2'b00: begin
        mbe_n   = 4'b0001 << addr_i[1:0];
        wdata_n = {4{rs2_val_i[7:0]}};
      end
      2'b01: begin
        mis_raw = addr_i[0];
        mbe_n   = 4'b0011 << addr_i[1:0];
        wdata_n = {2{rs2_val_i[15:0]}};
      end
      default: begin
        mis_raw = |addr_i[1:0];
        wdata_n = rs2_val_i;
      end
    endcase
    // Loads always fetch the whole word; lane selection happens on return.
    if (mem_read_i) begin
      mbe_n   = 4'hF;
      wdata_n = 32'h0;
    end
    misalign_o = mem_op & mis_raw;
    go         = mem_op & ~mis_raw;
  end

  assign timeout = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

  // Lane extraction uses the offset and funct3 latched at issue time.
  always_comb begin
    ld_byte = 8'h0;
    case (off_q)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = 8'h0;
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_BUSY;
          stall_o = 1'b1;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (dmem_resp || timeout) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      rd_q      <= 1'b0;
      mbe_q     <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      load_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          wait_cnt  <= '0;
          bus_err_q <= 1'b0;
          if (go) begin
            addr_q  <= addr_i[31:2];
            off_q   <= addr_i[1:0];
            f3_q    <= funct3_i;
            rd_q    <= mem_read_i;
            mbe_q   <= mbe_n;
            wdata_q <= wdata_n;
          end
        end
        S_BUSY: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A response in the final wait cycle still counts as success.
          if (dmem_resp) begin
            load_q    <= rd_q ? ld_ext : 32'h0;
            bus_err_q <= 1'b0;
          end else if (timeout) begin
            load_q    <= 32'h0;
            bus_err_q <= 1'b1;
          end
        end
        default: begin
          wait_cnt  <= '0;
          bus_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_address = {addr_q, 2'b00};
  assign dmem_read    = (state == S_BUSY) & rd_q;
  assign dmem_write   = (state == S_BUSY) & ~rd_q;
  assign dmem_mbe     = mbe_q;
  assign dmem_wdata   = wdata_q;
  assign load_data_o  = load_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, rs2_val_i;
  logic [31:0] dmem_address;
  logic        dmem_read, dmem_write;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data_o;
  logic        stall_o, misalign_o, bus_err_o;

  int checks = 0;
  int errors = 0;
  int req_starts = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .rs2_val_i(rs2_val_i), .dmem_address(dmem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .load_data_o(load_data_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always @(negedge clk) begin
    if ((dmem_read | dmem_write) && !req_prev) req_starts++;
    req_prev = dmem_read | dmem_write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One memory instruction: counts stall cycles, responds after resp_after
  // request cycles (0 = never), and records what the request looked like.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int resp_after, input logic [31:0] rdata, input bit hold,
                        output int stalls, output int busy, output int bad,
                        output logic [31:0] a_seen, output logic [3:0] m_seen,
                        output logic [31:0] w_seen, output logic rd_seen,
                        output logic wr_seen, output logic [31:0] ld,
                        output logic berr, output logic done);
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    addr_i = a; rs2_val_i = d; dmem_resp = 1'b0;
    stalls = 0; busy = 0; bad = 0; done = 1'b0;
    a_seen = '0; m_seen = '0; w_seen = '0; rd_seen = 1'b0; wr_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (i == 0) begin
        if (dmem_read || dmem_write) bad++;
      end else if (!(dmem_read || dmem_write)) begin
        bad++;
      end else begin
        busy++;
        if (busy == 1) begin
          a_seen = dmem_address; m_seen = dmem_mbe; w_seen = dmem_wdata;
          rd_seen = dmem_read; wr_seen = dmem_write;
        end else if (dmem_address !== a_seen || dmem_mbe !== m_seen ||
                     dmem_wdata !== w_seen || dmem_read !== rd_seen) begin
          bad++;
        end
        addr_i = a + 32'h40;
        rs2_val_i = ~d;
        if (busy == resp_after) begin
          dmem_resp = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(negedge clk);
      dmem_resp = 1'b0;
      dmem_rdata = 32'h0;
    end
    ld = load_data_o;
    berr = bus_err_o;
    if (!hold) begin
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    end
  endtask

  int st, bz, bd, r0;
  logic [31:0] as, ws, ld;
  logic [3:0] ms;
  logic rs, wsf, be, dn;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_i = 0; mem_read_i = 0; mem_write_i = 0;
    funct3_i = 0; addr_i = 0; rs2_val_i = 0; dmem_resp = 0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_read", {31'b0, dmem_read}, 0);
    check("rst_write", {31'b0, dmem_write}, 0);
    check("rst_mbe", {28'b0, dmem_mbe}, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_load", load_data_o, 0);
    check("rst_berr", {31'b0, bus_err_o}, 0);
    check("rst_stall", {31'b0, stall_o}, 0);
    rst_n = 1'b1;

    // LW 0x100, response in the third request cycle
    access(1, 0, 3'b010, 32'h100, 0, 3, 32'hDEADBEEF, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("lw_done", {31'b0, dn}, 1);
    check("lw_stall", st, 4);
    check("lw_busy", bz, 3);
    check("lw_req_shape", bd, 0);
    check("lw_addr", as, 32'h100);
    check("lw_mbe", {28'b0, ms}, 32'hF);
    check("lw_rd", {30'b0, rs, wsf}, 32'h2);
    check("lw_data", ld, 32'hDEADBEEF);
    check("lw_berr", {31'b0, be}, 0);

    // Reset while BUSY, then a stray response
    @(negedge clk);
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h400;
    @(negedge clk); #1;
    check("rb_busy_read", {31'b0, dmem_read}, 1);
    rst_n = 1'b0; valid_i = 0; mem_read_i = 0;
    @(negedge clk);
    rst_n = 1'b1; dmem_resp = 1; dmem_rdata = 32'h55AA55AA; #1;
    check("rb_read_low", {31'b0, dmem_read}, 0);
    check("rb_stall_low", {31'b0, stall_o}, 0);
    check("rb_load_clr", load_data_o, 0);
    @(negedge clk);
    dmem_resp = 0; dmem_rdata = 0; #1;
    check("rb_stray_load", load_data_o, 0);
    check("rb_stray_berr", {31'b0, bus_err_o}, 0);
    check("rb_idle_req", {30'b0, dmem_read, dmem_write}, 0);

    // Sub-word loads; LB also shows the 2-cycle minimum stall
    access(1, 0, 3'b000, 32'h103, 0, 1, 32'h80123456, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("lb_data", ld, 32'hFFFFFF80);
    check("lb_min_stall", st, 2);
    check("lb_addr", as, 32'h100);
    access(1, 0, 3'b100, 32'h103, 0, 2, 32'h80123456, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("lbu_data", ld, 32'h00000080);
    access(1, 0, 3'b000, 32'h101, 0, 1, 32'h00007F00, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("lb_pos_data", ld, 32'h0000007F);
    access(1, 0, 3'b101, 32'h102, 0, 1, 32'h80017777, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("lhu_data", ld, 32'h00008001);
    access(1, 0, 3'b001, 32'h102, 0, 1, 32'h80017777, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("lh_data", ld, 32'hFFFF8001);

    // Timeout after four request cycles, error pulse lasts one cycle
    access(1, 0, 3'b010, 32'h300, 0, 0, 0, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("to_done", {31'b0, dn}, 1);
    check("to_busy", bz, 4);
    check("to_stall", st, 5);
    check("to_berr", {31'b0, be}, 1);
    check("to_load", ld, 0);
    @(negedge clk); #1;
    check("to_berr_pulse", {31'b0, bus_err_o}, 0);

    // Response coincides with the last wait cycle: success wins
    access(1, 0, 3'b010, 32'h304, 0, 4, 32'hCAFEF00D, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("tr_berr", {31'b0, be}, 0);
    check("tr_data", ld, 32'hCAFEF00D);
    check("tr_busy", bz, 4);

    // Stores
    access(0, 1, 3'b000, 32'h201, 32'h12345678, 1, 32'hFFFFFFFF, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("sb_addr", as, 32'h200);
    check("sb_mbe", {28'b0, ms}, 32'h2);
    check("sb_wdata", ws, 32'h78787878);
    check("sb_wr", {30'b0, rs, wsf}, 32'h1);
    check("sb_load", ld, 0);
    access(0, 1, 3'b001, 32'h202, 32'h12345678, 2, 0, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("sh_mbe", {28'b0, ms}, 32'hC);
    check("sh_wdata", ws, 32'h56785678);
    check("sh_shape", bd, 0);

    // Misaligned and non-memory instructions
    @(negedge clk);
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h102; #1;
    check("mis_lw_flag", {31'b0, misalign_o}, 1);
    check("mis_lw_stall", {31'b0, stall_o}, 0);
    @(negedge clk); #1;
    check("mis_lw_req", {30'b0, dmem_read, dmem_write}, 0);
    mem_read_i = 0; mem_write_i = 1; funct3_i = 3'b001; addr_i = 32'h101; #1;
    check("mis_sh_flag", {31'b0, misalign_o}, 1);
    check("mis_sh_stall", {31'b0, stall_o}, 0);
    @(negedge clk); #1;
    check("mis_sh_req", {30'b0, dmem_read, dmem_write}, 0);
    mem_write_i = 0; funct3_i = 3'b010; addr_i = 32'h103; #1;
    check("nonmem_flag", {31'b0, misalign_o}, 0);
    check("nonmem_stall", {31'b0, stall_o}, 0);
    @(negedge clk); #1;
    check("nonmem_req", {30'b0, dmem_read, dmem_write}, 0);
    valid_i = 0;

    // Back-to-back LW then SW; LW stays on the inputs through its DONE cycle
    r0 = req_starts;
    access(1, 0, 3'b010, 32'h500, 0, 2, 32'h11112222, 1, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("bb_lw_data", ld, 32'h11112222);
    access(0, 1, 3'b010, 32'h204, 32'h12345678, 1, 0, 0, st, bz, bd, as, ms, ws, rs, wsf, ld, be, dn);
    check("bb_sw_addr", as, 32'h204);
    check("bb_sw_mbe", {28'b0, ms}, 32'hF);
    check("bb_sw_wdata", ws, 32'h12345678);
    check("bb_sw_load", ld, 0);
    @(negedge clk); #1;
    check("bb_issue_count", req_starts - r0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
